traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 The block SHALL have parameter GUARD_CYCLES, default 2, giving the number of clk cycles after a start_timer pulse during which expired is ignored.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-003 The block SHALL have port Reset_Sync, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port Sensor, input, 1 bit: asynchronous side-street car sensor, level.
REQ-005 The block SHALL have port Walk_Request, input, 1 bit: asynchronous pedestrian button, pulse or level.
REQ-006 The block SHALL have port expired, input, 1 bit: interval-elapsed level from the downstream timer.
REQ-007 The block SHALL have port start_timer, output, 1 bit: one-cycle request that starts a new interval.
REQ-008 The block SHALL have port interval, output, 2 bits: interval select to the time-parameter stage (00 base, 01 extended, 10 yellow, 11 unused).
REQ-009 The block SHALL have port Main_RYG, output, 3 bits: main-street lamps {red, yellow, green}.
REQ-010 The block SHALL have port Side_RYG, output, 3 bits: side-street lamps {red, yellow, green}.
REQ-011 The block SHALL have port Walk, output, 1 bit: pedestrian walk lamp.

Function
REQ-012 Sensor and Walk_Request SHALL each pass through a two-flop synchronizer before use.
REQ-013 The states SHALL be INIT, MG_BASE, MG_EXT, MY, WALK, SG_BASE, SG_EXT and SY, with all outputs registered and decoded from the state.
REQ-014 Transitions SHALL be: INIT->MG_BASE unconditionally; MG_BASE->(synced Sensor ? MG_EXT : MY); MG_EXT->MY; MY->(walk_pending ? WALK : SG_BASE); WALK->SG_BASE; SG_BASE->(synced Sensor ? SG_EXT : SY); SG_EXT->SY; SY->MG_BASE.
REQ-015 Every transition except the one out of INIT SHALL occur on the rising edge where expired=1 and the guard counter=0.
REQ-016 start_timer SHALL be high for exactly the first cycle the state register holds a new timed state, and low otherwise.
REQ-017 interval SHALL be valid in that same cycle and held stable for the whole state: 00 in MG_BASE and SG_BASE, 01 in MG_EXT, SG_EXT and WALK, 10 in MY and SY.
REQ-018 On each start_timer pulse the guard counter SHALL load GUARD_CYCLES and decrement to 0, saturating.
REQ-019 expired=1 while the guard counter is nonzero SHALL be ignored; this covers the stale expired level and the timer's one-cycle load latency.
REQ-020 Lamps SHALL be: MG_*: Main=001, Side=100; MY: Main=010, Side=100; WALK: Main=100, Side=100, Walk=1; SG_*: Main=100, Side=001; SY: Main=100, Side=010; INIT: Main=100, Side=100.
REQ-021 Exactly one Main bit and one Side bit SHALL be set at all times, and the two streets SHALL never be non-red at once.
REQ-022 walk_pending SHALL set on a synchronized Walk_Request high and clear on entry to WALK; set SHALL win over clear in the same cycle.
REQ-023 Sensor SHALL be sampled only on the expiring edge of MG_BASE or SG_BASE, so a change at any other time has no effect.

Reset
REQ-024 While Reset_Sync is high, state SHALL be INIT, Main_RYG=100, Side_RYG=100, Walk=0, start_timer=0, interval=00, guard counter=0, walk_pending=0, and synchronizers=0.
REQ-025 Reset asserted mid-interval SHALL force the INIT outputs immediately, without waiting for a clock edge.
REQ-026 On the first clk edge after Reset_Sync falls, the block SHALL enter MG_BASE with start_timer=1.

Configuration
REQ-027 With macro PEDESTRIAN_WALK_EN defined, the WALK state, walk_pending and the Walk_Request synchronizer SHALL exist as specified.
REQ-028 Without PEDESTRIAN_WALK_EN, MY SHALL always go to SG_BASE, Walk SHALL be tied to 0, Walk_Request SHALL be ignored, and no walk logic SHALL be synthesized.

Verification
REQ-029 Scenario: release reset with a timer model that asserts expired 6 cycles after start -> start_timer pulses, interval=00 and Main=001 in cycle 1, then MY with interval=10.
REQ-030 Scenario: hold Sensor=1 through MG_BASE -> MG_EXT with interval=01 follows, and likewise SG_EXT after SG_BASE.
REQ-031 Scenario: hold expired=1 constantly -> each state lasts exactly GUARD_CYCLES+1 cycles, and start_timer pulses once per state.
REQ-032 Scenario (PEDESTRIAN_WALK_EN): 1-cycle Walk_Request during MG_BASE -> after MY, WALK with Main=100, Side=100, Walk=1, then SG_BASE, and walk_pending is clear.
REQ-033 Scenario: assert Reset_Sync mid-SG_BASE between clock edges -> Side=100 and Main=100 at once; after release, MG_BASE with start_timer=1 on the first edge.
REQ-034 Scenario (macro undefined): Walk_Request=1 for 100 cycles -> WALK is never entered and Walk stays 0.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// Purpose : Two-street traffic light sequencer with an optional pedestrian phase; it drives an external interval timer.
// Latency : Outputs are registered from the next state, so lamps/start_timer/interval change on the edge the state changes.
// Backpressure: none; expired is qualified by a guard counter so stale or not-yet-loaded timer levels are ignored.
//
// Ports:
//   clk          - system clock, rising edge
//   Reset_Sync   - asynchronous active-high reset (forces INIT lamps immediately)
//   Sensor       - side-street car sensor (async level, synchronized internally)
//   Walk_Request - pedestrian button (async, synchronized internally; ignored without PEDESTRIAN_WALK_EN)
//   expired      - interval-elapsed level from the downstream timer
//   start_timer  - one-cycle pulse in the first cycle of each timed state
//   interval     - interval select: 00 base, 01 extended, 10 yellow
//   Main_RYG     - main-street lamps {red, yellow, green}
//   Side_RYG     - side-street lamps {red, yellow, green}
//   Walk         - pedestrian walk lamp
//
// Build option: define PEDESTRIAN_WALK_EN to include the WALK phase, walk_pending and the
// Walk_Request synchronizer. Without it MY always proceeds to SG_BASE and Walk is tied low.
module traffic_light_fsm #(
    parameter int GUARD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       Sensor,
    input  logic       Walk_Request,
    input  logic       expired,
    output logic       start_timer,
    output logic [1:0] interval,
    output logic [2:0] Main_RYG,
    output logic [2:0] Side_RYG,
    output logic       Walk
);

    localparam int            GW         = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        MG_BASE = 3'd1,
        MG_EXT  = 3'd2,
        MY      = 3'd3,
        WALK    = 3'd4,
        SG_BASE = 3'd5,
        SG_EXT  = 3'd6,
        SY      = 3'd7
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [GW-1:0] guard_q;
    logic [GW-1:0] guard_d;
    logic          sensor_meta;
    logic          sensor_sync;
    logic          advance;
    logic          entering;

    logic [2:0]    main_d;
    logic [2:0]    side_d;
    logic [1:0]    interval_d;

    // Sensor synchronizer
    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            sensor_meta <= 1'b0;
            sensor_sync <= 1'b0;
        end else begin
            sensor_meta <= Sensor;
            sensor_sync <= sensor_meta;
        end
    end

`ifdef PEDESTRIAN_WALK_EN
    logic walk_meta;
    logic walk_sync;
    logic walk_pending;
    logic walk_d;

    // Walk_Request synchronizer and the latched request; a new request in the
    // same cycle as WALK entry keeps the flag set so it is served next round.
    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            walk_meta    <= 1'b0;
            walk_sync    <= 1'b0;
            walk_pending <= 1'b0;
        end else begin
            walk_meta <= Walk_Request;
            walk_sync <= walk_meta;
            if (walk_sync) begin
                walk_pending <= 1'b1;
            end else if (state_d == WALK && state_q != WALK) begin
                walk_pending <= 1'b0;
            end
        end
    end
`else
    logic unused_walk_request;
    assign unused_walk_request = Walk_Request;
    assign Walk                = 1'b0;
`endif

    // A timed state may only end once the guard has drained.
    assign advance  = expired && (guard_q == '0);
    assign entering = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = MG_BASE;
            MG_BASE: if (advance) state_d = sensor_sync ? MG_EXT : MY;
            MG_EXT:  if (advance) state_d = MY;
            MY: begin
                if (advance) begin
`ifdef PEDESTRIAN_WALK_EN
                    state_d = walk_pending ? WALK : SG_BASE;
`else
                    state_d = SG_BASE;
`endif
                end
            end
`ifdef PEDESTRIAN_WALK_EN
            WALK:    if (advance) state_d = SG_BASE;
`endif
            SG_BASE: if (advance) state_d = sensor_sync ? SG_EXT : SY;
            SG_EXT:  if (advance) state_d = SY;
            SY:      if (advance) state_d = MG_BASE;
            default: state_d = INIT;
        endcase
    end

    // Guard loads together with the start_timer pulse, then drains to zero.
    always_comb begin
        guard_d = guard_q;
        if (entering) begin
            guard_d = GUARD_LOAD;
        end else if (guard_q != '0) begin
            guard_d = guard_q - GW'(1);
        end
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        main_d     = 3'b100;
        side_d     = 3'b100;
        interval_d = 2'b00;
        case (state_d)
            MG_BASE: begin main_d = 3'b001; interval_d = 2'b00; end
            MG_EXT:  begin main_d = 3'b001; interval_d = 2'b01; end
            MY:      begin main_d = 3'b010; interval_d = 2'b10; end
            WALK:    begin interval_d = 2'b01; end
            SG_BASE: begin side_d = 3'b001; interval_d = 2'b00; end
            SG_EXT:  begin side_d = 3'b001; interval_d = 2'b01; end
            SY:      begin side_d = 3'b010; interval_d = 2'b10; end
            default: begin end
        endcase
    end

`ifdef PEDESTRIAN_WALK_EN
    assign walk_d = (state_d == WALK);
`endif

    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            state_q     <= INIT;
            guard_q     <= '0;
            start_timer <= 1'b0;
            interval    <= 2'b00;
            Main_RYG    <= 3'b100;
            Side_RYG    <= 3'b100;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            start_timer <= entering;
            interval    <= interval_d;
            Main_RYG    <= main_d;
            Side_RYG    <= side_d;
        end
    end

`ifdef PEDESTRIAN_WALK_EN
    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            Walk <= 1'b0;
        end else begin
            Walk <= walk_d;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Purpose : Randomized self-checking bench for traffic_light_fsm against a phase/age reference model.
// Latency : Model advances once per rising edge; DUT outputs are sampled 1 time unit after the edge.
// Backpressure: n/a; expired is driven either randomly, held high, or by a simple interval-timer model.
module tb_traffic_light_fsm;

    localparam int G = 2;

    // Phase indices of the reference model
    localparam int P_INIT = 0;
    localparam int P_MGB  = 1;
    localparam int P_MGE  = 2;
    localparam int P_MY   = 3;
    localparam int P_WALK = 4;
    localparam int P_SGB  = 5;
    localparam int P_SGE  = 6;
    localparam int P_SY   = 7;

    logic       clk          = 1'b0;
    logic       Reset_Sync   = 1'b1;
    logic       Sensor       = 1'b0;
    logic       Walk_Request = 1'b0;
    logic       expired      = 1'b0;
    logic       start_timer;
    logic [1:0] interval;
    logic [2:0] Main_RYG;
    logic [2:0] Side_RYG;
    logic       Walk;

    traffic_light_fsm #(.GUARD_CYCLES(G)) dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .expired      (expired),
        .start_timer  (start_timer),
        .interval     (interval),
        .Main_RYG     (Main_RYG),
        .Side_RYG     (Side_RYG),
        .Walk         (Walk)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int ph   = P_INIT;
    int age  = 0;
    bit pend = 1'b0;
    bit s_h1 = 1'b0;
    bit s_h2 = 1'b0;
    bit w_h1 = 1'b0;
    bit w_h2 = 1'b0;

    // Stimulus control
    int mode        = 0;   // 0 random expired, 1 expired held high, 2 timer model
    bit sens_rand   = 1'b0;
    bit walk_rand   = 1'b0;
    int tcnt        = 0;
    int walk_cycles = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_main(input int p);
        case (p)
            P_MGB, P_MGE: return 3'b001;
            P_MY:         return 3'b010;
            default:      return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input int p);
        case (p)
            P_SGB, P_SGE: return 3'b001;
            P_SY:         return 3'b010;
            default:      return 3'b100;
        endcase
    endfunction

    function automatic logic [1:0] exp_interval(input int p);
        case (p)
            P_MGE, P_SGE, P_WALK: return 2'b01;
            P_MY, P_SY:           return 2'b10;
            default:              return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        ph   = P_INIT;
        age  = 0;
        pend = 1'b0;
        s_h1 = 1'b0;
        s_h2 = 1'b0;
        w_h1 = 1'b0;
        w_h2 = 1'b0;
    endtask

    // One rising edge of the reference model: inputs seen two edges ago are
    // the ones the sequencer acts on; a timed phase ends once it is at least
    // G cycles old and expired is high.
    task automatic model_edge();
        bit s_syn;
        bit w_syn;
        int nxt;
        if (Reset_Sync) begin
            model_reset();
            return;
        end
        s_syn = s_h2;
        w_syn = w_h2;
        s_h2  = s_h1;
        s_h1  = Sensor;
        w_h2  = w_h1;
        w_h1  = Walk_Request;
        nxt   = ph;
        if (ph == P_INIT) begin
            nxt = P_MGB;
        end else if (expired && age >= G) begin
            case (ph)
                P_MGB:  nxt = s_syn ? P_MGE : P_MY;
                P_MGE:  nxt = P_MY;
`ifdef PEDESTRIAN_WALK_EN
                P_MY:   nxt = pend ? P_WALK : P_SGB;
`else
                P_MY:   nxt = P_SGB;
`endif
                P_WALK: nxt = P_SGB;
                P_SGB:  nxt = s_syn ? P_SGE : P_SY;
                P_SGE:  nxt = P_SY;
                default: nxt = P_MGB;
            endcase
        end
        if (w_syn) begin
            pend = 1'b1;
        end else if (nxt == P_WALK && ph != P_WALK) begin
            pend = 1'b0;
        end
        age = (nxt != ph) ? 0 : age + 1;
        ph  = nxt;
    endtask

    task automatic check_all();
        check("main_ryg", 8'(Main_RYG), 8'(exp_main(ph)));
        check("side_ryg", 8'(Side_RYG), 8'(exp_side(ph)));
        check("walk", 8'(Walk), 8'(ph == P_WALK));
        check("start_timer", 8'(start_timer), 8'(ph != P_INIT && age == 0));
        check("interval", 8'(interval), 8'(exp_interval(ph)));
        check("one_hot_main", 8'($countones(Main_RYG)), 8'd1);
        check("one_hot_side", 8'($countones(Side_RYG)), 8'd1);
        check("both_non_red", 8'(Main_RYG[2] == 1'b0 && Side_RYG[2] == 1'b0), 8'd0);
`ifdef PEDESTRIAN_WALK_EN
        check("walk_pending", 8'(dut.walk_pending), 8'(pend));
`endif
    endtask

    task automatic drive();
        case (mode)
            1:       expired = 1'b1;
            2:       expired = (tcnt >= 6);
            default: expired = ($urandom_range(0, 3) == 0);
        endcase
        if (sens_rand && $urandom_range(0, 7) == 0) Sensor = ~Sensor;
        if (walk_rand) Walk_Request = ($urandom_range(0, 19) == 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (Walk) walk_cycles++;
        if (start_timer) tcnt = 0;
        else tcnt++;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int target, input int bound, input string tag);
        int k;
        k = 0;
        while (ph != target && k < bound) begin
            step();
            k++;
        end
        check(tag, 8'(ph == target), 8'd1);
    endtask

    initial begin
        model_reset();

        // Reset state held over a few edges
        run(3);

        // Release with a timer that expires 6 cycles after each start
        mode = 2;
        Reset_Sync = 1'b0;
        run(40);

        // Sensor held high: extended greens on both streets
        Sensor = 1'b1;
        run(60);

        // expired held high: every phase lasts G+1 cycles
        mode = 1;
        run(60);
        Sensor = 1'b0;

`ifdef PEDESTRIAN_WALK_EN
        // Single-cycle walk request during main green
        mode = 2;
        run_until(P_MGB, 200, "reach_mg_base");
        Walk_Request = 1'b1;
        step();
        Walk_Request = 1'b0;
        walk_cycles = 0;
        run(80);
        check("walk_seen", 8'(walk_cycles > 0), 8'd1);
`else
        // Walk_Request held high for 100 cycles has no effect
        mode = 2;
        walk_cycles = 0;
        Walk_Request = 1'b1;
        run(100);
        Walk_Request = 1'b0;
        check("walk_never", 8'(walk_cycles), 8'd0);
`endif

        // Random traffic
        mode = 0;
        sens_rand = 1'b1;
        walk_rand = 1'b1;
        run(2000);
        walk_rand = 1'b0;
        Walk_Request = 1'b0;

        // Asynchronous reset in the middle of side green
        mode = 2;
        run_until(P_SGB, 500, "reach_sg_base");
        #2;
        Reset_Sync = 1'b1;
        model_reset();
        #1;
        check_all();
        run(2);
        Reset_Sync = 1'b0;
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
